// File: rtl/pipe_stage_buf.sv
// Pipeline stage register carrying a PC and a payload, with an optional skid entry and flush.
// Latency: one cycle from in_fire to out_valid. Throughput is one beat per cycle with no bubbles.
// Backpressure: SKID=1 gives a registered in_ready (!s_valid). SKID=0 passes out_ready combinationally.
module pipe_stage_buf #(
    parameter int              PC_W     = 32,
    parameter int              DATA_W   = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'hbfc00000),
    parameter bit              SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main entry drives the outputs. The skid entry catches one beat while downstream stalls.
    logic              r_m_valid;
    logic [PC_W-1:0]   r_m_pc;
    logic [DATA_W-1:0] r_m_data;
    logic              r_s_valid;
    logic [PC_W-1:0]   r_s_pc;
    logic [DATA_W-1:0] r_s_data;
    logic [1:0]        r_occ;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_m_valid_nxt;
    logic [PC_W-1:0]   w_m_pc_nxt;
    logic [DATA_W-1:0] w_m_data_nxt;
    logic              w_s_valid_nxt;
    logic [PC_W-1:0]   w_s_pc_nxt;
    logic [DATA_W-1:0] w_s_data_nxt;

    // With a skid entry, in_ready depends only on state. Without one, a stalled M
    // can accept a new beat only when downstream drains it in the same cycle.
    assign in_ready   = SKID ? !r_s_valid : (!r_m_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_m_valid && out_ready;

    assign out_valid  = r_m_valid;
    assign out_pc     = r_m_pc;
    assign out_data   = r_m_data;
    assign occupancy  = r_occ;

    // Next-state selection for both entries. An emptied entry always returns to RESET_PC/0.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_pc_nxt    = r_m_pc;
        w_m_data_nxt  = r_m_data;
        w_s_valid_nxt = r_s_valid;
        w_s_pc_nxt    = r_s_pc;
        w_s_data_nxt  = r_s_data;
        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_m_pc_nxt    = RESET_PC;
            w_m_data_nxt  = '0;
            w_s_valid_nxt = 1'b0;
            w_s_pc_nxt    = RESET_PC;
            w_s_data_nxt  = '0;
        end else if (SKID) begin
            if (w_out_fire && r_s_valid) begin
                // Promote the skid beat. in_ready is low, so no new beat arrives.
                w_m_valid_nxt = 1'b1;
                w_m_pc_nxt    = r_s_pc;
                w_m_data_nxt  = r_s_data;
                w_s_valid_nxt = 1'b0;
                w_s_pc_nxt    = RESET_PC;
                w_s_data_nxt  = '0;
            end else if (w_out_fire) begin
                w_m_valid_nxt = w_in_fire;
                w_m_pc_nxt    = w_in_fire ? in_pc   : RESET_PC;
                w_m_data_nxt  = w_in_fire ? in_data : '0;
            end else if (!r_m_valid) begin
                if (w_in_fire) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_pc_nxt    = in_pc;
                    w_m_data_nxt  = in_data;
                end
            end else if (w_in_fire) begin
                // M is stalled. Park the new beat in S.
                w_s_valid_nxt = 1'b1;
                w_s_pc_nxt    = in_pc;
                w_s_data_nxt  = in_data;
            end
        end else begin
            if (w_in_fire) begin
                w_m_valid_nxt = 1'b1;
                w_m_pc_nxt    = in_pc;
                w_m_data_nxt  = in_data;
            end else if (w_out_fire) begin
                w_m_valid_nxt = 1'b0;
                w_m_pc_nxt    = RESET_PC;
                w_m_data_nxt  = '0;
            end
        end
    end

    // Entry registers and registered occupancy. rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_pc    <= RESET_PC;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_pc    <= RESET_PC;
            r_s_data  <= '0;
            r_occ     <= 2'd0;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_m_pc    <= w_m_pc_nxt;
            r_m_data  <= w_m_data_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_s_pc    <= w_s_pc_nxt;
            r_s_data  <= w_s_data_nxt;
            r_occ     <= {1'b0, w_m_valid_nxt} + {1'b0, w_s_valid_nxt};
        end
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register for the CPU pipeline (IF/ID, ID/EX, ...); successor to the fixed 32-bit PC-only stage register.
- Carries a PC field plus a generic payload under a valid/ready handshake. Optional 1-entry skid buffer breaks the combinational ready path.
- Supports flush (bubble insertion) with a programmable bubble PC.
- Sits between two pipeline stages; upstream is the producer, downstream is the consumer.

Parameters:
- PC_W, 32, width of PC field
- DATA_W, 64, width of payload (instruction word, control bits, etc.)
- RESET_PC, 32'hbfc00000, PC value held in any empty/flushed entry and after reset
- SKID, 1, 1 = main + skid entry (registered in_ready); 0 = main entry only (combinational in_ready)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all held entries this cycle
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept beat
- in_pc  input  PC_W  upstream PC
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  downstream beat present (main entry valid)
- out_ready  input  1  downstream accepts beat (low = downstream stall)
- out_pc  output  PC_W  main entry PC
- out_data  output  DATA_W  main entry payload
- occupancy  output  2  number of valid entries (0..2; max 1 when SKID=0)

Behaviour:
- Storage:
  - Main entry M (m_valid, m_pc, m_data) drives the outputs directly.
  - Skid entry S (s_valid, s_pc, s_data) is present only when SKID=1.
- Reset (rst=1 at a clock edge):
  - m_valid = s_valid = 0; m_pc = s_pc = RESET_PC; m_data = s_data = 0.
  - Resulting outputs: out_valid=0, out_pc=RESET_PC, out_data=0, occupancy=0.
  - in_ready=1 after reset.
  - rst overrides flush and every handshake; held entries are lost mid-operation.
- Events:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
- in_ready:
  - SKID=1: in_ready = !s_valid (register-derived, no path from out_ready).
  - SKID=0: in_ready = !m_valid || out_ready.
- Flush (priority below rst, above all else):
  - Next cycle m_valid=s_valid=0 and m_pc=s_pc=RESET_PC; data is don't-care and held at 0.
  - A beat presented with in_fire in the flush cycle is discarded. Upstream treats it as consumed.
  - out_fire in the flush cycle still counts as a completed transfer for downstream.
- Update, SKID=1, no flush (evaluate in order):
  - out_fire && s_valid: M <= S; S is cleared. in_fire cannot occur because in_ready=0.
  - out_fire && !s_valid: if in_fire, M <= input; otherwise M is cleared (m_pc=RESET_PC).
  - !out_fire && !m_valid: if in_fire, M <= input.
  - !out_fire && m_valid: if in_fire, S <= input. M holds.
- Update, SKID=0, no flush:
  - If in_fire, M <= input.
  - Else if out_fire, M is cleared (m_pc=RESET_PC).
  - Else M holds.
- Invariants:
  - Strict FIFO order; no beat is duplicated or dropped except by flush.
  - Zero-bubble throughput when in_valid and out_ready are continuously high: 1 beat/cycle, latency 1 cycle.
  - out_pc, out_data and out_valid are stable while out_valid && !out_ready, unless flush occurs.
  - An empty entry always holds PC=RESET_PC.
- occupancy = m_valid + s_valid, registered along with the entries.
- Full boundary: s_valid=1 forces in_ready=0. Upstream must hold its beat.
- Empty boundary: out_valid=0 with out_ready=1 has no effect.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_pc=0x80000000 -> out_valid=0, out_pc=0xbfc00000, occupancy=0, in_ready=1 after reset.
- Streaming (SKID=1): send PCs 0x100, 0x104, 0x108 on consecutive cycles with out_ready=1 -> out_pc shows 0x100, 0x104, 0x108 one cycle later each, occupancy stays 1, no bubbles.
- Downstream stall: with 0x200 in M, hold out_ready=0 and present 0x204 -> S captures 0x204, occupancy=2, in_ready=0. 0x208 stays held upstream. Release out_ready -> outputs 0x200, 0x204, 0x208 in order.
- Flush with full buffer: occupancy=2, assert flush with in_valid=1 and in_pc=0x300 -> next cycle out_valid=0, out_pc=0xbfc00000, occupancy=0. 0x300 never appears at the output.
- Reset mid-stall: occupancy=2, assert rst together with flush and out_ready=1 -> all entries cleared and out_pc=0xbfc00000; no beat emerges afterward.
- SKID=0 build: out_ready=0 with M valid -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally and the new beat replaces M next cycle; occupancy never exceeds 1.
